// File: rtl/npc_if.sv
// Bundle between the ID/hazard logic and the fetch-side PC unit.
// The master drives the decode/redirect inputs, and the slave (npc_unit) drives the registered fetch outputs.
interface npc_if;
    // No valid/ready pair here: the outputs are valid every cycle after reset, and stall is the
    // only back-pressure. While stall is high, the unit accepts nothing and holds every output.
    logic        stall;
    logic [2:0]  cmp_rst;
    logic [2:0]  br_type;
    logic [1:0]  jump_type;
    logic [31:0] id_pc4;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] jr_target;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        bd;
    logic        adel_f;

    modport master (
        output stall, cmp_rst, br_type, jump_type, id_pc4, imm16, instr_index,
        output jr_target, exc_req, eret_req, epc,
        input  pc, pc4, bd, adel_f
    );

    modport slave (
        input  stall, cmp_rst, br_type, jump_type, id_pc4, imm16, instr_index,
        input  jr_target, exc_req, eret_req, epc,
        output pc, pc4, bd, adel_f
    );
endinterface

// File: rtl/npc_unit.sv
// IF-stage PC register and next-PC select for branches, jumps, exceptions and eret.
// Define NPC_EXC_EN to enable the exception/eret redirect and the fetch misalignment flag.
module npc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic  clk,
    input  logic  reset,
    npc_if.slave  bus
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc4_q, pc4_d;
    logic        bd_q, bd_d;
    logic        adel_q, adel_d;

    logic        br_taken;
    logic        br_any;
    logic        jmp_any;
    logic [31:0] br_target;
    logic [31:0] jmp_target;

    always_comb begin
        br_taken = 1'b0;
        case (bus.br_type)
            3'b001:  br_taken = bus.cmp_rst[0];
            3'b010:  br_taken = !bus.cmp_rst[0];
            3'b011:  br_taken = bus.cmp_rst[1];
            3'b100:  br_taken = !bus.cmp_rst[1];
            3'b101:  br_taken = bus.cmp_rst[1] && !bus.cmp_rst[2];
            3'b110:  br_taken = !bus.cmp_rst[1] || bus.cmp_rst[2];
            default: br_taken = 1'b0;
        endcase
        br_any  = (bus.br_type != 3'b000) && (bus.br_type != 3'b111);
        jmp_any = (bus.jump_type == 2'b01) || (bus.jump_type == 2'b10);

        br_target  = bus.id_pc4 + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
        jmp_target = (bus.jump_type == 2'b10) ? bus.jr_target
                                              : {bus.id_pc4[31:28], bus.instr_index, 2'b00};

        pc_d = pc_q;
        bd_d = bd_q;
`ifdef NPC_EXC_EN
        if (bus.exc_req) begin
            pc_d = EXC_VECTOR;
            bd_d = 1'b0;
        end else if (bus.eret_req) begin
            pc_d = bus.epc;
            bd_d = 1'b0;
        end else if (!bus.stall) begin
`else
        if (!bus.stall) begin
`endif
            // Not-taken branches still set bd: the next fetch is their delay slot either way.
            if (jmp_any)       pc_d = jmp_target;
            else if (br_taken) pc_d = br_target;
            else               pc_d = pc_q + 32'd4;
            bd_d = br_any || jmp_any;
        end

        pc4_d = pc_d + 32'd4;
`ifdef NPC_EXC_EN
        // Holding pc_d == pc_q keeps this equal to the stored flag, so it also holds during stall.
        adel_d = (pc_d[1:0] != 2'b00);
`else
        adel_d = 1'b0;
`endif
    end

`ifndef NPC_EXC_EN
    logic unused_exc;
    assign unused_exc = ^{bus.exc_req, bus.eret_req, bus.epc};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            pc4_q  <= RESET_PC + 32'd4;
            bd_q   <= 1'b0;
            adel_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            pc4_q  <= pc4_d;
            bd_q   <= bd_d;
            adel_q <= adel_d;
        end
    end

    assign bus.pc     = pc_q;
    assign bus.pc4    = pc4_q;
    assign bus.bd     = bd_q;
    assign bus.adel_f = adel_q;

endmodule

// File: tb/tb_npc_unit.sv
// Directed bench for npc_unit: a driver pushes hand-computed register values into a queue, and a monitor pops and compares them.
// Expectations follow the build: exception rows differ when NPC_EXC_EN is defined.
module tb_npc_unit;

    logic clk;
    logic reset;
    npc_if bus ();

    npc_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Packed expectation: {pc, pc4, bd, adel_f}.
    logic [65:0] exp_q[$];
    int          tag_q[$];
    int          n_checks;
    int          n_fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_idle();
        bus.stall       = 1'b0;
        bus.cmp_rst     = 3'b000;
        bus.br_type     = 3'b000;
        bus.jump_type   = 2'b00;
        bus.id_pc4      = 32'h0;
        bus.imm16       = 16'h0;
        bus.instr_index = 26'h0;
        bus.jr_target   = 32'h0;
        bus.exc_req     = 1'b0;
        bus.eret_req    = 1'b0;
        bus.epc         = 32'h0;
    endtask

    // Apply the current inputs across one rising edge and queue the state expected after it.
    task automatic step(input int tag, input logic [31:0] e_pc, input logic e_bd, input logic e_adel);
        @(posedge clk);
        exp_q.push_back({e_pc, e_pc + 32'd4, e_bd, e_adel});
        tag_q.push_back(tag);
        #1;
        set_idle();
        reset = 1'b0;
    endtask

    // Monitor: the outputs are valid every cycle, so compare at each falling edge when a row is pending.
    initial begin
        logic [65:0] exp;
        logic [65:0] got;
        int          tag;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                tag = tag_q.pop_front();
                got = {bus.pc, bus.pc4, bus.bd, bus.adel_f};
                n_checks++;
                if (got !== exp) begin
                    n_fails++;
                    $display("FAIL step%0d: got pc=%h pc4=%h bd=%b adel=%b, want pc=%h pc4=%h bd=%b adel=%b",
                             tag, got[65:34], got[33:2], got[1], got[0],
                             exp[65:34], exp[33:2], exp[1], exp[0]);
                end
            end
        end
    end

    initial begin
        logic exc_on;
`ifdef NPC_EXC_EN
        exc_on = 1'b1;
`else
        exc_on = 1'b0;
`endif
        n_checks = 0;
        n_fails  = 0;
        set_idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        step(1, 32'h3000, 1'b0, 1'b0);
        step(2, 32'h3004, 1'b0, 1'b0);
        step(3, 32'h3008, 1'b0, 1'b0);

        // beq taken back to 0x3000, then the same beq not taken.
        bus.br_type = 3'b001; bus.cmp_rst = 3'b001; bus.id_pc4 = 32'h3008; bus.imm16 = 16'hFFFE;
        step(4, 32'h3000, 1'b1, 1'b0);
        bus.br_type = 3'b001; bus.cmp_rst = 3'b000; bus.id_pc4 = 32'h3008; bus.imm16 = 16'hFFFE;
        step(5, 32'h3004, 1'b1, 1'b0);
        step(6, 32'h3008, 1'b0, 1'b0);

        // bgtz with A==0 is not taken; blez with A==0 is taken.
        bus.br_type = 3'b101; bus.cmp_rst = 3'b110; bus.id_pc4 = 32'h3008; bus.imm16 = 16'h0004;
        step(7, 32'h300C, 1'b1, 1'b0);
        bus.br_type = 3'b110; bus.cmp_rst = 3'b110; bus.id_pc4 = 32'h300C; bus.imm16 = 16'h0004;
        step(8, 32'h301C, 1'b1, 1'b0);
        bus.br_type = 3'b010; bus.cmp_rst = 3'b000; bus.id_pc4 = 32'h3020; bus.imm16 = 16'h0010;
        step(9, 32'h3060, 1'b1, 1'b0);
        bus.br_type = 3'b011; bus.cmp_rst = 3'b010; bus.id_pc4 = 32'h3064; bus.imm16 = 16'hFFF0;
        step(10, 32'h3024, 1'b1, 1'b0);
        bus.br_type = 3'b100; bus.cmp_rst = 3'b010; bus.id_pc4 = 32'h3028; bus.imm16 = 16'h0040;
        step(11, 32'h3028, 1'b1, 1'b0);
        // Reserved branch type behaves as no branch.
        bus.br_type = 3'b111; bus.cmp_rst = 3'b001; bus.id_pc4 = 32'h302C; bus.imm16 = 16'h0040;
        step(12, 32'h302C, 1'b0, 1'b0);

        // j keeps the upper nibble of id_pc4; reserved jump type is ignored.
        bus.jump_type = 2'b01; bus.id_pc4 = 32'h3030; bus.instr_index = 26'h0000C10;
        step(13, 32'h3040, 1'b1, 1'b0);
        bus.jump_type = 2'b11; bus.jr_target = 32'h5000; bus.instr_index = 26'h0000C10;
        step(14, 32'h3044, 1'b0, 1'b0);

        // jr held two stall cycles, then taken to a misaligned target.
        for (int i = 0; i < 2; i++) begin
            bus.stall = 1'b1; bus.jump_type = 2'b10; bus.jr_target = 32'h3011;
            step(15 + i, 32'h3044, 1'b0, 1'b0);
        end
        bus.jump_type = 2'b10; bus.jr_target = 32'h3011;
        step(17, 32'h3011, 1'b1, exc_on);
        step(18, 32'h3015, 1'b0, exc_on);
        bus.jump_type = 2'b01; bus.id_pc4 = 32'h3000; bus.instr_index = 26'h0000C20;
        step(19, 32'h3080, 1'b1, 1'b0);

        // Exception beats stall and a taken beq; then eret to EPC.
        bus.exc_req = 1'b1; bus.stall = 1'b1;
        bus.br_type = 3'b001; bus.cmp_rst = 3'b001; bus.id_pc4 = 32'h3084; bus.imm16 = 16'h0004;
        if (exc_on) step(20, 32'h4180, 1'b0, 1'b0);
        else        step(20, 32'h3080, 1'b1, 1'b0);
        bus.eret_req = 1'b1; bus.epc = 32'h3020;
        if (exc_on) step(21, 32'h3020, 1'b0, 1'b0);
        else        step(21, 32'h3084, 1'b0, 1'b0);
        // Simultaneous exception and eret: exception wins.
        bus.exc_req = 1'b1; bus.eret_req = 1'b1; bus.epc = 32'h3020;
        if (exc_on) step(22, 32'h4180, 1'b0, 1'b0);
        else        step(22, 32'h3088, 1'b0, 1'b0);

        // Reset wins over a concurrent jump.
        reset = 1'b1; bus.jump_type = 2'b01; bus.id_pc4 = 32'h3000; bus.instr_index = 26'h0000C40;
        step(23, 32'h3000, 1'b0, 1'b0);
        step(24, 32'h3004, 1'b0, 1'b0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL drain: %0d expected rows never compared, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/npc_unit.md
# npc_unit

Fetch-side program counter register and next-PC selector for the 5-stage MIPS pipeline. It consumes the branch condition flags that the ID-stage comparator produces and the ID-stage jump and branch decode. It holds the IF-stage PC and redirects it for branches, jumps, exceptions and `eret`. All outputs are registered and feed instruction memory and the IF/ID pipeline register.

## Interface
Parameters:
- `RESET_PC`, `32'h0000_3000`, PC value loaded on reset.
- `EXC_VECTOR`, `32'h0000_4180`, exception handler entry.

Ports:
- `clk` in 1: the only clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hazard unit freeze; PC and flags hold.
- `cmp_rst` in 3: comparator flags. Bit 0 is `A==B`, bit 1 is `A>=0` (A[31]==0), bit 2 is `A==0`.
- `br_type` in 3: branch type in ID. `000` none, `001` beq, `010` bne, `011` bgez, `100` bltz, `101` bgtz, `110` blez, `111` reserved (treated as none).
- `jump_type` in 2: jump type in ID. `00` none, `01` j/jal, `10` jr/jalr, `11` reserved (treated as none).
- `id_pc4` in 32: PC+4 of the ID instruction.
- `imm16` in 16: branch offset.
- `instr_index` in 26: j/jal field.
- `jr_target` in 32: forwarded rs value.
- `exc_req` in 1: exception commit from M stage.
- `eret_req` in 1: `eret` in ID.
- `epc` in 32: CP0 EPC.
- `pc` out 32: current fetch address.
- `pc4` out 32: `pc+4`, registered alongside `pc`.
- `bd` out 1: the instruction now in IF is a delay slot.
- `adel_f` out 1: `pc` is misaligned (fetch address error).

## Operation
- Taken-condition decode:
  - beq: `c0`.
  - bne: `!c0`.
  - bgez: `c1`.
  - bltz: `!c1`.
  - bgtz: `c1 & !c2`.
  - blez: `!c1 | c2`.
- Target computation, all 32-bit with wrap-around, no overflow detection:
  - Branch: `id_pc4 + {{14{imm16[15]}},imm16,2'b00}`.
  - j/jal: `{id_pc4[31:28],instr_index,2'b00}`.
  - jr/jalr: `jr_target`.
- Next-PC priority, highest first:
  1. `reset`: load `RESET_PC`.
  2. `exc_req`: load `EXC_VECTOR`.
  3. `eret_req`: load `epc`.
  4. `stall`: hold.
  5. Taken branch or any jump: load target.
  6. Otherwise: `pc+4`.
- `exc_req` and `eret_req` override `stall`.
- Not-taken branches fall through to `pc+4`. Architectural delay slot: the IF instruction at resolution time always executes.
- `bd` register:
  - On a non-stalled edge, loads 1 if `br_type` or `jump_type` is non-none (taken or not), else 0.
  - Cleared by `reset`, `exc_req` and `eret_req`.
  - Holds during `stall`.
- `adel_f` register: loads `next_pc[1:0]!=0` whenever `pc` loads.
- `pc4` register always equals `pc+4` of the stored `pc`.

## Timing
- Reset values: `pc=RESET_PC`, `pc4=RESET_PC+4`, `bd=0`, `adel_f=0`.
- Latency: a redirect decided in cycle N is visible on `pc` in cycle N+1. Zero bubbles, because the delay slot covers the fetch.
- `stall` high for k cycles holds every output for k cycles. A branch held in ID during a stall is re-evaluated each cycle; only the cmp flags of the first non-stalled cycle matter.
- Simultaneous `exc_req` and a taken branch: exception wins and `bd=0`.
- Simultaneous `exc_req` and `eret_req`: exception wins.
- `reset` asserted mid-redirect: `RESET_PC` wins on that edge.

## Configuration
- `NPC_EXC_EN` defined:
  - `exc_req`/`eret_req` behave as specified.
  - `adel_f` is computed from the next PC.
- `NPC_EXC_EN` undefined:
  - `exc_req`, `eret_req` and `epc` are ignored (ports remain).
  - `adel_f` is tied to 0.
  - Priority reduces to reset > stall > branch/jump > pc+4.

## Test plan
- Release `reset` with no ID branch/jump activity -> `pc` = `0x3000`, `0x3004`, `0x3008` on successive cycles; `bd=0` throughout.
- `id_pc4=0x3008`, `br_type=001`, `cmp_rst=3'b001`, `imm16=16'hFFFE`, stall 0 -> next `pc=0x3000`, `bd=1`. Same stimulus with `cmp_rst=3'b000` -> `pc=pc+4`, `bd=1`.
- bgtz with `cmp_rst=3'b110` (A==0) -> not taken. blez with `cmp_rst=3'b110` -> taken to `id_pc4+(imm16<<2)`.
- `jump_type=10`, `jr_target=0x3011`, stall held 2 cycles then released -> `pc` unchanged during the stall, then `0x3011` with `adel_f=1` (with `NPC_EXC_EN`).
- `exc_req=1` together with `stall=1` and a taken beq -> next `pc=0x4180`, `bd=0`. Next cycle: `eret_req=1`, `epc=0x3020` -> `pc=0x3020`.
- Undefine `NPC_EXC_EN`, pulse `exc_req` -> `pc` continues `+4`; `adel_f` stays 0 after a `jr` to `0x3011`.
